// File: rtl/logic_unit_seq_pkg.sv
// Shared ALU logic-op encodings and FSM states for the sliced logic unit.
// The ALU top-level decoder reuses the op encodings.
package logic_unit_seq_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-wide bitwise op; one instance is time-shared across
// all slices of the latched operands.
module logic_slice
  import logic_unit_seq_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  op_e              op_i,
  output logic [SLICE-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: computes WIDTH-bit AND/OR/XOR/NOR
// SLICE bits per clock with a start/busy/done handshake.
module logic_unit_seq
  import logic_unit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  op_e              op_q;
  logic             busy_q, done_q, zero_q;

  logic [31:0]      ofs;
  logic [WIDTH-1:0] a_sh, b_sh, res_d;
  logic [SLICE-1:0] y_sl;

  // Shift the active slice down to bit 0 rather than using a variable part-select.
  always_comb begin
    ofs  = 32'(idx_q) * 32'(SLICE);
    a_sh = a_q >> ofs;
    b_sh = b_q >> ofs;
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a_i  (a_sh[SLICE-1:0]),
    .b_i  (b_sh[SLICE-1:0]),
    .op_i (op_q),
    .y_o  (y_sl)
  );

  always_comb begin
    res_d = (result_q & ~(SMASK << ofs)) | (WIDTH'(y_sl) << ofs);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          result_q <= res_d;
          if (idx_q == IW'(N - 1)) begin
            zero_q  <= (res_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op_e'(op);
            result_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq: directed vectors, random ops
// against a whole-word reference, and handshake/reset corner sequences.
module tb_logic_unit_seq;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero;
  logic [31:0] result;
  logic        busy2, done2, zero2;
  logic [31:0] result2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy2), .done(done2), .result(result2), .zero(zero2)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive a request; returns at the negedge after the accepting edge with start low.
  task automatic accept(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count remaining busy cycles (bounded), then check the done cycle.
  task automatic wait_done(input string nm, input int exp_busy, input logic [31:0] exp);
    int c = 0;
    while (busy === 1'b1 && c < 100) begin
      c++;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, 32'(c), 32'(exp_busy));
    chk({nm, " done"}, {31'd0, done}, 32'd1);
    chk({nm, " result"}, result, exp);
    chk({nm, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    vec_t v;
    logic [31:0] r1, r2;
    int gap;

    vecs.push_back('{2'b00, 32'hA5A5_F00F, 32'h0F0F_FFFF, 32'h0505_F00F});
    vecs.push_back('{2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000});
    vecs.push_back('{2'b01, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001});
    vecs.push_back('{2'b11, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001});

    // Reset state
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd0);
    chk("reset result N=1", result2, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; operands scrambled after accept must not matter
    foreach (vecs[i]) begin
      v = vecs[i];
      accept(v.op, v.a, v.b);
      a = $urandom; b = $urandom; op = 2'($urandom);
      chk($sformatf("vec%0d busy after accept", i), {31'd0, busy}, 32'd1);
      wait_done($sformatf("vec%0d", i), N, v.exp);
      @(negedge clk);
      chk($sformatf("vec%0d done width", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d result held", i), result, v.exp);
    end

    // Random ops vs whole-word reference
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] x, y;
      o = 2'($urandom); x = $urandom; y = (i % 5 == 0) ? x : $urandom;
      accept(o, x, y);
      wait_done($sformatf("rand%0d", i), N, ref_op(o, x, y));
    end

    // Start pulse during RUN is ignored
    accept(2'b11, 32'h0, 32'hFFFF_0000);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = '1; b = '1;
    @(negedge clk);
    start = 1'b0;
    wait_done("run start ignored", N - 2, 32'h0000_FFFF);
    @(negedge clk);
    chk("no restart after ignored start", {31'd0, busy}, 32'd0);

    // Back-to-back: start held through DONE with new operands
    r1 = ref_op(2'b10, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    r2 = ref_op(2'b00, 32'hCAFE_F00D, 32'hFFFF_0000);
    @(negedge clk);
    op = 2'b10; a = 32'hDEAD_BEEF; b = 32'h0F0F_0F0F; start = 1'b1;
    @(negedge clk);
    op = 2'b00; a = 32'hCAFE_F00D; b = 32'hFFFF_0000;
    wait_done("b2b first", N, r1);
    gap = 0;
    @(negedge clk);
    start = 1'b0;
    gap++;
    chk("b2b accepted in DONE", {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b done spacing", 32'(gap), 32'(N + 1));
    chk("b2b second result", result, r2);
    chk("b2b second zero", {31'd0, zero}, {31'd0, r2 == 32'd0});

    // Async reset mid-stream, checked before the next edge
    accept(2'b01, 32'h1111_1111, 32'h2222_2222);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    chk("async rst result", result, 32'd0);
    chk("async rst zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) seen++;
      end
      chk("no done after abort", 32'(seen), 32'd0);
    end
    chk("result cleared after abort", result, 32'd0);
    accept(2'b00, 32'hA5A5_F00F, 32'h0F0F_FFFF);
    wait_done("after abort", N, 32'h0505_F00F);

    // Single-slice instance: one RUN cycle then DONE
    @(negedge clk);
    @(negedge clk);
    op = 2'b00; a = 32'hA5A5_F00F; b = 32'h0F0F_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("N1 busy", {31'd0, busy2}, 32'd1);
    chk("N1 done early", {31'd0, done2}, 32'd0);
    @(negedge clk);
    chk("N1 busy end", {31'd0, busy2}, 32'd0);
    chk("N1 done", {31'd0, done2}, 32'd1);
    chk("N1 result", result2, 32'h0505_F00F);
    chk("N1 zero", {31'd0, zero2}, 32'd0);
    @(negedge clk);
    chk("N1 done width", {31'd0, done2}, 32'd0);
    wait_done("N8 alongside N1", N - 2, 32'h0505_F00F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
